cla_serial_subtractor_16bit: RTL and testbench
==============================================

Name: cla_serial_subtractor_16bit

Overview:
- Multi-cycle 16-bit subtractor with borrow: computes diff = in1 - in2 - b_in by iterating one 4-bit carry-lookahead slice over four nibbles, LSB nibble first.
- Carries the ripple between nibbles in a register, which makes it the area-reduced counterpart to the single-cycle 16-bit CLA adder in the arithmetic library.
- Sits behind a start/done handshake so the datapath controller can issue one operation at a time.

Parameters:
- WIDTH, 16, operand width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; NSTEPS = WIDTH/SLICE = 4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only when ready=1.
- in1  in  WIDTH  minuend; captured on the accepted start edge.
- in2  in  WIDTH  subtrahend; captured on the accepted start edge.
- b_in  in  1  borrow in; captured on the accepted start edge.
- ready  out  1  high only in IDLE.
- diff  out  WIDTH  result; held until the next accepted start.
- b_out  out  1  borrow out (1 when in1 < in2 + b_in, unsigned).
- ovf  out  1  two's-complement overflow of the signed subtraction.
- done  out  1  one-cycle pulse when diff/b_out/ovf are valid.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, ready=1, done=0, diff=0, b_out=0, ovf=0, step counter=0, carry register=0.
- Arithmetic: in1 + ~in2 + carry, with carry initialised to ~b_in.
- Per CALC cycle, the slice takes nibble k of the captured in1 and of ~in2 plus the carry register. Its sum is written to diff[k*SLICE +: SLICE] and its carry-out goes to the carry register.
- b_out = ~(final carry-out).
- ovf = (in1[15] != in2[15]) && (diff[15] != in1[15]), using the captured operands.
- FSM has three states:
  - IDLE: ready=1. start=1 at an edge -> capture operands, clear diff, carry=~b_in, step=0, go to CALC.
  - CALC: ready=0. Process nibble `step` each edge. At step=NSTEPS-1, write b_out/ovf and go to DONE; otherwise step+1.
  - DONE: done=1 for exactly this cycle, ready=0. Next edge -> IDLE.
- Latency: start accepted at edge T0; nibbles processed at T1..T4; done=1 during the cycle after T4; ready returns after T5. Issue-to-issue interval is 6 cycles.
- start during CALC or DONE is ignored (not queued). Operand changes after T0 have no effect.
- start high continuously: a new operation is accepted at every IDLE edge, one per 6 cycles.
- diff is not valid while CALC is in progress. Consumers sample diff only on done.
- Reset asserted mid-CALC aborts the operation. Outputs return to reset values and no done pulse is produced.
- Counter wrap: step never exceeds NSTEPS-1. Any unreachable state encoding returns to IDLE.

Decomposition:
- Shared package arith_pkg:
  - FSM state encoding constants (ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2).
  - WIDTH/SLICE defaults.
  - NSTEPS and step counter width (clog2(NSTEPS)).
- One sub-module: cla_4bit_slice. It is combinational, with inputs a[3:0], b[3:0], c_in and outputs sum[3:0], c_out, p, g. All generate/propagate lookahead lives there.
- The top level holds only the FSM, operand/carry registers and result assembly.

Test Plan:
- in1=40535, in2=25000, b_in=0, start pulse -> done 5 cycles after start edge; diff=15535, b_out=0, ovf=0.
- in1=25000, in2=40535, b_in=0 -> diff=50001, b_out=1, ovf=0.
- in1=16785, in2=3245, b_in=1 -> diff=13539, b_out=0.
- Overflow and borrow cases:
  - in1=16'h8000, in2=16'h0001 -> diff=16'h7FFF, ovf=1, b_out=0.
  - in1=16'h7FFF, in2=16'hFFFF -> diff=16'h8000, ovf=1, b_out=1.
  - in1=0, in2=0, b_in=1 -> diff=16'hFFFF, b_out=1, ovf=0.
- Handshake and reset:
  - Second start pulse with different operands during CALC -> ignored; only the first result appears; ready stays 0 until after DONE.
  - rst asserted for 1 cycle at step=2 -> immediately ready=1, done=0, diff=0; no done pulse follows.
  - A fresh operation afterwards completes correctly.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: default datapath geometry and the
// serial subtractor's controller state encoding.
package arith_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_SLICE = 4;
   localparam int NSTEPS    = DEF_WIDTH / DEF_SLICE;
   localparam int STEP_W    = $clog2(NSTEPS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cla_serial_subtractor_16bit_if.sv
// Start/done operation bus between the datapath controller (master) and the
// serial subtractor (slave).
interface cla_serial_subtractor_16bit_if #(
   parameter int WIDTH = arith_pkg::DEF_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             b_in;
   logic             ready;
   logic [WIDTH-1:0] diff;
   logic             b_out;
   logic             ovf;
   logic             done;

   modport master (
      output start, in1, in2, b_in,
      input  ready, diff, b_out, ovf, done
   );

   modport slave (
      input  start, in1, in2, b_in,
      output ready, diff, b_out, ovf, done
   );
endinterface

// File: rtl/cla_4bit_slice.sv
// Combinational 4-bit carry-lookahead adder slice with group propagate and
// generate outputs for chaining.
module cla_4bit_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       c_out,
   output logic       p,
   output logic       g
);
   logic [3:0] w_p;
   logic [3:0] w_g;
   logic [3:0] w_c;

   assign w_p = a ^ b;
   assign w_g = a & b;

   assign w_c[0] = c_in;
   assign w_c[1] = w_g[0] | (w_p[0] & c_in);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & c_in);

   assign p = &w_p;
   assign g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

   assign c_out = g | (p & c_in);
   assign sum   = w_p ^ w_c;
endmodule

// File: rtl/cla_serial_subtractor_16bit.sv
// Multi-cycle subtractor: diff = in1 - in2 - b_in, one CLA nibble per cycle,
// LSB first, with the inter-nibble carry held in a register.
module cla_serial_subtractor_16bit
   import arith_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic clk,
   input  logic rst,
   cla_serial_subtractor_16bit_if.slave bus
);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

   state_t             r_state;
   logic [STEP_W-1:0]  r_step;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b_n;
   logic               r_carry;
   logic [WIDTH-1:0]   r_diff;
   logic               r_b_out;
   logic               r_ovf;
   logic               r_ready;
   logic               r_done;

   logic [SLICE-1:0]   w_a_nib;
   logic [SLICE-1:0]   w_b_nib;
   logic [SLICE-1:0]   w_sum;
   logic               w_cout;
   logic               w_grp_p;
   logic               w_grp_g;
   logic               w_final_c;

   assign w_a_nib = r_a[r_step*SLICE +: SLICE];
   assign w_b_nib = r_b_n[r_step*SLICE +: SLICE];

   cla_4bit_slice u_slice (
      .a     (w_a_nib),
      .b     (w_b_nib),
      .c_in  (r_carry),
      .sum   (w_sum),
      .c_out (w_cout),
      .p     (w_grp_p),
      .g     (w_grp_g)
   );

   // Final carry rebuilt from the group terms; the borrow is its complement.
   assign w_final_c = w_grp_g | (w_grp_p & r_carry);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_step  <= '0;
         r_a     <= '0;
         r_b_n   <= '0;
         r_carry <= 1'b0;
         r_diff  <= '0;
         r_b_out <= 1'b0;
         r_ovf   <= 1'b0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_a     <= bus.in1;
                  r_b_n   <= ~bus.in2;
                  r_carry <= ~bus.b_in;
                  r_diff  <= '0;
                  r_step  <= '0;
                  r_ready <= 1'b0;
                  r_state <= ST_CALC;
               end
            end
            ST_CALC: begin
               r_diff[r_step*SLICE +: SLICE] <= w_sum;
               r_carry <= w_cout;
               if (r_step == LAST_STEP) begin
                  r_b_out <= ~w_final_c;
                  // Operand signs differ when in1[MSB] equals ~in2[MSB].
                  r_ovf   <= (r_a[WIDTH-1] == r_b_n[WIDTH-1]) &&
                             (w_sum[SLICE-1] != r_a[WIDTH-1]);
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_step <= r_step + 1'b1;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_step  <= '0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_step  <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ready = r_ready;
   assign bus.diff  = r_diff;
   assign bus.b_out = r_b_out;
   assign bus.ovf   = r_ovf;
   assign bus.done  = r_done;
endmodule

// File: tb/tb_cla_serial_subtractor_16bit.sv
// Directed plus randomized checks of the serial subtractor against a plain
// integer-arithmetic reference.
module tb_cla_serial_subtractor_16bit;
   import arith_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cla_serial_subtractor_16bit_if #(.WIDTH(DEF_WIDTH)) bus ();

   cla_serial_subtractor_16bit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_asserts = 0;
   int n_fail    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic ref_sub(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          output logic [15:0] d, output logic bo, output logic ov);
      int unsigned ua, ub, ib;
      int sa, sb, si, r;
      ua = a; ub = b; ib = bin;
      sa = $signed(a); sb = $signed(b); si = ib;
      r  = sa - sb - si;
      d  = 16'(ua - ub - ib);
      bo = (ua < ub + ib);
      ov = (r < -32768) || (r > 32767);
   endtask

   // Issue one operation from an idle negedge and check result and timing.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input string tag);
      logic [15:0] ed;
      logic        eb, eo;
      int          cyc, rdy_hi;
      ref_sub(a, b, bin, ed, eb, eo);
      bus.in1 = a; bus.in2 = b; bus.b_in = bin; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.in1 = ~a; bus.in2 = ~b; bus.b_in = ~bin;
      cyc = 1; rdy_hi = 0;
      while (!bus.done && cyc < 20) begin
         if (bus.ready) rdy_hi++;
         @(negedge clk);
         cyc++;
      end
      chk({tag, " latency"}, cyc, 5);
      chk({tag, " diff"}, {16'd0, bus.diff}, {16'd0, ed});
      chk({tag, " b_out"}, {31'd0, bus.b_out}, {31'd0, eb});
      chk({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
      chk({tag, " ready_busy"}, {31'd0, bus.ready}, 32'd0);
      chk({tag, " ready_calc"}, rdy_hi, 0);
      @(negedge clk);
      chk({tag, " done_pulse"}, {31'd0, bus.done}, 32'd0);
      chk({tag, " ready_back"}, {31'd0, bus.ready}, 32'd1);
   endtask

   initial begin
      logic [15:0] ed, ra, rb;
      logic        eb, eo;
      int          cyc, t1, t2, nd;

      rst = 1'b1;
      bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.b_in = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("rst ready", {31'd0, bus.ready}, 32'd1);
      chk("rst done", {31'd0, bus.done}, 32'd0);
      chk("rst diff", {16'd0, bus.diff}, 32'd0);
      chk("rst b_out", {31'd0, bus.b_out}, 32'd0);
      chk("rst ovf", {31'd0, bus.ovf}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      do_op(16'd40535, 16'd25000, 1'b0, "op1");
      do_op(16'd25000, 16'd40535, 1'b0, "op2");
      do_op(16'd16785, 16'd3245, 1'b1, "op3");
      do_op(16'h8000, 16'h0001, 1'b0, "ovf_neg");
      do_op(16'h7FFF, 16'hFFFF, 1'b0, "ovf_pos");
      do_op(16'h0000, 16'h0000, 1'b1, "zero_bin");

      // Result holds while idle.
      repeat (3) @(negedge clk);
      chk("hold diff", {16'd0, bus.diff}, 32'h0000FFFF);
      chk("hold b_out", {31'd0, bus.b_out}, 32'd1);

      // Second start during CALC is dropped.
      bus.in1 = 16'd1000; bus.in2 = 16'd1; bus.b_in = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk); @(negedge clk);
      bus.in1 = 16'd5; bus.in2 = 16'd7; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("ign ready", {31'd0, bus.ready}, 32'd0);
      cyc = 4;
      while (!bus.done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("ign latency", cyc, 5);
      chk("ign diff", {16'd0, bus.diff}, 32'd999);
      @(negedge clk); @(negedge clk);
      chk("ign no_queue", {31'd0, bus.ready}, 32'd1);

      // Start held high: one accept per 6 cycles.
      ra = 16'd300; rb = 16'd500;
      ref_sub(ra, rb, 1'b0, ed, eb, eo);
      bus.in1 = ra; bus.in2 = rb; bus.b_in = 1'b0; bus.start = 1'b1;
      cyc = 0; t1 = -1; t2 = -1;
      while (t2 < 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (bus.done) begin
            if (t1 < 0) t1 = cyc;
            else t2 = cyc;
         end
      end
      bus.start = 1'b0;
      chk("cont interval", t2 - t1, 6);
      chk("cont diff", {16'd0, bus.diff}, {16'd0, ed});
      chk("cont b_out", {31'd0, bus.b_out}, {31'd0, eb});
      @(negedge clk);
      chk("cont idle", {31'd0, bus.ready}, 32'd1);

      // Reset mid-CALC at step 2 aborts without a done pulse.
      do_op(16'h0000, 16'h0001, 1'b0, "pre_rst");
      bus.in1 = 16'h1234; bus.in2 = 16'h4321; bus.b_in = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst ready", {31'd0, bus.ready}, 32'd1);
      chk("mid_rst done", {31'd0, bus.done}, 32'd0);
      chk("mid_rst diff", {16'd0, bus.diff}, 32'd0);
      chk("mid_rst b_out", {31'd0, bus.b_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.done) nd++;
      end
      chk("mid_rst no_done", nd, 0);
      do_op(16'hBEEF, 16'h1234, 1'b1, "post_rst");

      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         do_op(ra, rb, 1'($urandom), $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
